// File: rtl/fpnew_pkg.sv
// Shared FP definitions used by the non-computational output stage.
// Contents:
//   fp_format_e  - supported floating-point formats
//   fp_width()   - bit width of a given format
//   status_t     - IEEE exception flags NV, DZ, OF, UF, NX (NV is the MSB)
//   classmask_e  - one-hot CLASSIFY result encoding (10 bits)
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef enum logic [9:0] {
        NEGINF     = 10'h001,
        NEGNORM    = 10'h002,
        NEGSUBNORM = 10'h004,
        NEGZERO    = 10'h008,
        POSZERO    = 10'h010,
        POSSUBNORM = 10'h020,
        POSNORM    = 10'h040,
        POSINF     = 10'h080,
        SNAN       = 10'h100,
        QNAN       = 10'h200
    } classmask_e;

endpackage

// File: rtl/fpnew_noncomp_out_stage.sv
// Output pipeline stage for the non-computational FP unit (SGNJ / MINMAX /
// CMP / CLASSIFY). The classification mask is folded into the result word
// before the first register, then result, status, extension bit, tag and aux
// travel through NumPipeRegs valid/ready register stages (0 = passthrough).
//
// Optional feature (macro FPNEW_NONCOMP_STICKY_STATUS_EN):
//   defined   - status_sticky_o accumulates status_o over every output
//               handshake; clear_sticky_i clears it.
//   undefined - status_sticky_o is tied to 0, clear_sticky_i is ignored.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   result_i .. aux_i     upstream payload, is_class_i selects the class mask
//   in_valid_i/in_ready_o upstream handshake
//   flush_i               drops every in-flight op (and the op offered now)
//   result_o .. aux_o     downstream payload
//   out_valid_o/out_ready_i downstream handshake
//   busy_o                any stage holds a valid op
//   status_sticky_o       accumulated flags, clear_sticky_i clears them
module fpnew_noncomp_out_stage #(
    parameter fpnew_pkg::fp_format_e FpFormat    = fpnew_pkg::fp_format_e'(0),
    parameter type                   TagType     = logic,
    parameter type                   AuxType     = logic,
    parameter int unsigned           NumPipeRegs = 1,
    localparam int unsigned          WIDTH       = fpnew_pkg::fp_width(FpFormat)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [WIDTH-1:0]       result_i,
    input  fpnew_pkg::status_t     status_i,
    input  logic                   extension_bit_i,
    input  fpnew_pkg::classmask_e  class_mask_i,
    input  logic                   is_class_i,
    input  TagType                 tag_i,
    input  AuxType                 aux_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       result_o,
    output fpnew_pkg::status_t     status_o,
    output logic                   extension_bit_o,
    output TagType                 tag_o,
    output AuxType                 aux_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   busy_o,
    output fpnew_pkg::status_t     status_sticky_o,
    input  logic                   clear_sticky_i
);

    typedef struct packed {
        logic [WIDTH-1:0]   result;
        fpnew_pkg::status_t status;
        logic               ext_bit;
        TagType             tag;
        AuxType             aux;
    } payload_t;

    payload_t         in_payload;
    payload_t         out_payload;
    logic             out_valid;
    logic [9:0]       class_bits;
    logic [WIDTH-1:0] class_word;

    // The size cast zero-extends for wide formats and keeps only the low
    // WIDTH bits for formats narrower than the 10-bit mask.
    assign class_bits = class_mask_i;
    assign class_word = WIDTH'(class_bits);

    always_comb begin
        in_payload.result  = result_i;
        in_payload.status  = status_i;
        in_payload.ext_bit = extension_bit_i;
        in_payload.tag     = tag_i;
        in_payload.aux     = aux_i;
        if (is_class_i) begin
            in_payload.result  = class_word;
            in_payload.ext_bit = 1'b0;
        end
    end

    if (NumPipeRegs == 0) begin : g_passthrough

        logic unused_seq;

        assign out_payload = in_payload;
        assign out_valid   = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign busy_o      = 1'b0;
        assign unused_seq  = ^{clk_i, rst_i, flush_i};

    end else begin : g_pipeline

        logic     [NumPipeRegs-1:0] stage_valid_q;
        payload_t                   stage_data_q [NumPipeRegs];
        logic     [NumPipeRegs:0]   stage_ready;
        logic     [NumPipeRegs:0]   chain_valid;
        payload_t                   chain_data   [NumPipeRegs+1];

        // chain_* index k is the upstream side of stage k; index N is the
        // output. Only register outputs feed the chain, so no comb loops.
        assign chain_valid = {stage_valid_q, in_valid_i};

        always_comb begin
            chain_data[0] = in_payload;
            for (int k = 0; k < NumPipeRegs; k++) begin
                chain_data[k+1] = stage_data_q[k];
            end
        end

        // A stage can take a new op when it is empty or its own op leaves.
        always_comb begin
            stage_ready              = '0;
            stage_ready[NumPipeRegs] = out_ready_i;
            for (int k = NumPipeRegs - 1; k >= 0; k--) begin
                stage_ready[k] = stage_ready[k+1] | ~stage_valid_q[k];
            end
        end

        // Flush only kills valid bits; the payload left behind is harmless.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stage_valid_q <= '0;
                for (int k = 0; k < NumPipeRegs; k++) begin
                    stage_data_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < NumPipeRegs; k++) begin
                    if (flush_i) begin
                        stage_valid_q[k] <= 1'b0;
                    end else if (stage_ready[k]) begin
                        stage_valid_q[k] <= chain_valid[k];
                    end
                    if (chain_valid[k] && stage_ready[k]) begin
                        stage_data_q[k] <= chain_data[k];
                    end
                end
            end
        end

        assign out_payload = chain_data[NumPipeRegs];
        assign out_valid   = chain_valid[NumPipeRegs];
        assign in_ready_o  = stage_ready[0];
        assign busy_o      = |stage_valid_q;

    end

    assign result_o        = out_payload.result;
    assign status_o        = out_payload.status;
    assign extension_bit_o = out_payload.ext_bit;
    assign tag_o           = out_payload.tag;
    assign aux_o           = out_payload.aux;
    assign out_valid_o     = out_valid;

`ifdef FPNEW_NONCOMP_STICKY_STATUS_EN
    fpnew_pkg::status_t sticky_q;
    logic               out_handshake;

    assign out_handshake = out_valid & out_ready_i;

    // A clear coinciding with a delivery restarts from that delivery's flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= '0;
        end else if (clear_sticky_i) begin
            sticky_q <= out_handshake ? out_payload.status : '0;
        end else if (out_handshake) begin
            sticky_q <= fpnew_pkg::status_t'(sticky_q | out_payload.status);
        end
    end

    assign status_sticky_o = sticky_q;
`else
    logic unused_clear;

    assign status_sticky_o = '0;
    assign unused_clear    = clear_sticky_i;
`endif

endmodule

// File: tb/tb_fpnew_noncomp_out_stage.sv
// Directed bench for fpnew_noncomp_out_stage. One instance per depth
// (NumPipeRegs = 0..3) shares the same stimulus; each scenario checks the
// instance whose depth it targets.
module tb_fpnew_noncomp_out_stage;
    import fpnew_pkg::*;

    typedef logic [7:0] tag_t;
    typedef logic [3:0] aux_t;

`ifdef FPNEW_NONCOMP_STICKY_STATUS_EN
    localparam bit StickyEn = 1'b1;
`else
    localparam bit StickyEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic        clear_sticky;
    logic        is_class;
    logic        ext_in;
    logic [31:0] result_in;
    status_t     status_in;
    classmask_e  class_mask_in;
    tag_t        tag_in;
    aux_t        aux_in;

    logic [31:0] res_o    [4];
    status_t     st_o     [4];
    logic        ext_o    [4];
    tag_t        tag_o    [4];
    aux_t        aux_o    [4];
    logic        ov_o     [4];
    logic        ir_o     [4];
    logic        busy_o   [4];
    status_t     sticky_o [4];

    int num_checks   = 0;
    int num_failures = 0;
    int seen;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fpnew_noncomp_out_stage #(
            .FpFormat   (FP32),
            .TagType    (tag_t),
            .AuxType    (aux_t),
            .NumPipeRegs(g)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .result_i       (result_in),
            .status_i       (status_in),
            .extension_bit_i(ext_in),
            .class_mask_i   (class_mask_in),
            .is_class_i     (is_class),
            .tag_i          (tag_in),
            .aux_i          (aux_in),
            .in_valid_i     (in_valid),
            .in_ready_o     (ir_o[g]),
            .flush_i        (flush),
            .result_o       (res_o[g]),
            .status_o       (st_o[g]),
            .extension_bit_o(ext_o[g]),
            .tag_o          (tag_o[g]),
            .aux_o          (aux_o[g]),
            .out_valid_o    (ov_o[g]),
            .out_ready_i    (out_ready),
            .busy_o         (busy_o[g]),
            .status_sticky_o(sticky_o[g]),
            .clear_sticky_i (clear_sticky)
        );
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input tag_t tag,
                                 input logic [31:0] result, input status_t status,
                                 input logic cls, input classmask_e mask,
                                 input logic ext);
        in_valid      = valid;
        tag_in        = tag;
        aux_in        = tag[3:0];
        result_in     = result;
        status_in     = status;
        is_class      = cls;
        class_mask_in = mask;
        ext_in        = ext;
    endtask

    task automatic applyReset();
        rst          = 1'b1;
        in_valid     = 1'b0;
        flush        = 1'b0;
        clear_sticky = 1'b0;
        tick();
        rst          = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        applyStimulus(1'b0, 8'd0, 32'h0, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
        applyReset();
        tick();
        #1;

        // Reset state of every registered depth.
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("rst_valid_n%0d", i),  64'(ov_o[i]),     64'd0);
            checkOutput($sformatf("rst_result_n%0d", i), 64'(res_o[i]),    64'd0);
            checkOutput($sformatf("rst_status_n%0d", i), 64'(st_o[i]),     64'd0);
            checkOutput($sformatf("rst_tag_n%0d", i),    64'(tag_o[i]),    64'd0);
            checkOutput($sformatf("rst_busy_n%0d", i),   64'(busy_o[i]),   64'd0);
            checkOutput($sformatf("rst_ready_n%0d", i),  64'(ir_o[i]),     64'd1);
            checkOutput($sformatf("rst_sticky_n%0d", i), 64'(sticky_o[i]), 64'd0);
        end

        // Classify merge, plus the N=0 combinational path.
        applyReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 8'd9, 32'hDEADBEEF, status_t'(5'b0), 1'b1, POSNORM, 1'b1);
        #1;
        checkOutput("n0_class_result", 64'(res_o[0]), 64'h40);
        checkOutput("n0_class_ext",    64'(ext_o[0]), 64'd0);
        checkOutput("n0_valid",        64'(ov_o[0]),  64'd1);
        checkOutput("n0_ready",        64'(ir_o[0]),  64'd1);
        checkOutput("n0_busy",         64'(busy_o[0]), 64'd0);
        tick();
        applyStimulus(1'b1, 8'd10, 32'h12345678, status_t'(5'b00010), 1'b0, POSNORM, 1'b1);
        #1;
        checkOutput("class_valid",  64'(ov_o[1]),  64'd1);
        checkOutput("class_result", 64'(res_o[1]), 64'h40);
        checkOutput("class_ext",    64'(ext_o[1]), 64'd0);
        checkOutput("class_tag",    64'(tag_o[1]), 64'd9);
        checkOutput("class_aux",    64'(aux_o[1]), 64'd9);
        checkOutput("n0_pass_result", 64'(res_o[0]), 64'h12345678);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("pass_result", 64'(res_o[1]), 64'h12345678);
        checkOutput("pass_ext",    64'(ext_o[1]), 64'd1);
        checkOutput("pass_status", 64'(st_o[1]),  64'b00010);
        checkOutput("n0_ready_low", 64'(ir_o[0]), 64'd0);

        // Streaming through two stages: tags appear two edges after offer.
        applyReset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            applyStimulus(cyc < 4, tag_t'(cyc + 1), 32'h0, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
            #1;
            checkOutput($sformatf("stream_ready_%0d", cyc), 64'(ir_o[2]), 64'd1);
            tick();
            checkOutput($sformatf("stream_valid_%0d", cyc), 64'(ov_o[2]),
                        64'(cyc >= 1 && cyc <= 4));
            if (cyc >= 1 && cyc <= 4)
                checkOutput($sformatf("stream_tag_%0d", cyc), 64'(tag_o[2]), 64'(cyc));
        end

        // Backpressure: two ops fill the pipe, the third waits upstream.
        applyReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'd5, 32'h0, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
        #1;
        checkOutput("bp_ready_5", 64'(ir_o[2]), 64'd1);
        tick();
        applyStimulus(1'b1, 8'd6, 32'h0, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
        #1;
        checkOutput("bp_ready_6", 64'(ir_o[2]), 64'd1);
        tick();
        applyStimulus(1'b1, 8'd7, 32'h0, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
        #1;
        checkOutput("bp_ready_full", 64'(ir_o[2]),  64'd0);
        checkOutput("bp_head_valid", 64'(ov_o[2]),  64'd1);
        checkOutput("bp_head_tag",   64'(tag_o[2]), 64'd5);
        tick();
        checkOutput("bp_hold_tag",   64'(tag_o[2]), 64'd5);
        checkOutput("bp_hold_ready", 64'(ir_o[2]),  64'd0);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(ir_o[2]), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        checkOutput("bp_out6_valid", 64'(ov_o[2]),  64'd1);
        checkOutput("bp_out6_tag",   64'(tag_o[2]), 64'd6);
        tick();
        checkOutput("bp_out7_valid", 64'(ov_o[2]),  64'd1);
        checkOutput("bp_out7_tag",   64'(tag_o[2]), 64'd7);
        tick();
        checkOutput("bp_drained_valid", 64'(ov_o[2]),   64'd0);
        checkOutput("bp_drained_busy",  64'(busy_o[2]), 64'd0);

        // Flush a full three-stage pipe while a new op is handshaken.
        applyReset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, tag_t'(i + 1), 32'h0, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checkOutput("fl_full_busy",  64'(busy_o[3]), 64'd1);
        checkOutput("fl_full_tag",   64'(tag_o[3]),  64'd1);
        checkOutput("fl_full_ready", 64'(ir_o[3]),   64'd0);
        out_ready = 1'b1;
        flush     = 1'b1;
        applyStimulus(1'b1, 8'd8, 32'h0, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
        #1;
        checkOutput("fl_ready", 64'(ir_o[3]), 64'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("fl_busy",  64'(busy_o[3]), 64'd0);
        checkOutput("fl_valid", 64'(ov_o[3]),   64'd0);
        seen = 0;
        repeat (5) begin
            tick();
            if (ov_o[3]) seen++;
        end
        checkOutput("fl_no_ghost", 64'(seen), 64'd0);

        // Reset while two ops sit in a stalled two-stage pipe.
        applyReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'd11, 32'hA5A5A5A5, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
        tick();
        applyStimulus(1'b1, 8'd12, 32'h5A5A5A5A, status_t'(5'b0), 1'b0, NEGINF, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        checkOutput("mr_pre_valid",  64'(ov_o[2]),  64'd1);
        checkOutput("mr_pre_result", 64'(res_o[2]), 64'hA5A5A5A5);
        checkOutput("mr_pre_ready",  64'(ir_o[2]),  64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mr_valid",  64'(ov_o[2]),   64'd0);
        checkOutput("mr_result", 64'(res_o[2]),  64'd0);
        checkOutput("mr_busy",   64'(busy_o[2]), 64'd0);
        checkOutput("mr_ready",  64'(ir_o[2]),   64'd1);

        // Sticky flags on the one-stage instance: NV then OF, then clear+NX.
        applyReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 8'd1, 32'h0, status_t'(5'b10000), 1'b0, NEGINF, 1'b0);
        tick();
        applyStimulus(1'b1, 8'd2, 32'h0, status_t'(5'b00100), 1'b0, NEGINF, 1'b0);
        #1;
        checkOutput("st_out_nv", 64'(st_o[1]), 64'b10000);
        tick();
        in_valid = 1'b0;
        #1;
        checkOutput("st_out_of",     64'(st_o[1]),     64'b00100);
        checkOutput("sticky_nv",     64'(sticky_o[1]), StickyEn ? 64'b10000 : 64'd0);
        tick();
        checkOutput("sticky_nv_of",  64'(sticky_o[1]), StickyEn ? 64'b10100 : 64'd0);
        applyStimulus(1'b1, 8'd3, 32'h0, status_t'(5'b00001), 1'b0, NEGINF, 1'b0);
        tick();
        in_valid     = 1'b0;
        clear_sticky = 1'b1;
        #1;
        checkOutput("st_out_nx",     64'(st_o[1]),     64'b00001);
        checkOutput("sticky_before", 64'(sticky_o[1]), StickyEn ? 64'b10100 : 64'd0);
        tick();
        checkOutput("sticky_nx_only", 64'(sticky_o[1]), StickyEn ? 64'b00001 : 64'd0);
        tick();
        clear_sticky = 1'b0;
        #1;
        checkOutput("sticky_cleared", 64'(sticky_o[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
        $finish;
    end

endmodule

// File: doc/fpnew_noncomp_out_stage.md
Name: fpnew_noncomp_out_stage

Overview:
- Output pipeline stage placed directly downstream of the non-computational FP unit (SGNJ/MINMAX/CMP/CLASSIFY).
- Registers that unit's result, status, extension bit, class mask, tag and aux through a configurable number of valid/ready pipeline registers.
- Folds the classification mask into the result word, so consumers see one result bus.
- Provides flush, a busy indication and optional sticky status accumulation.

Parameters:
- FpFormat, fpnew_pkg::fp_format_e'(0): FP format. WIDTH = fpnew_pkg::fp_width(FpFormat), derived, not overridable.
- TagType, logic: tag type, carried unchanged.
- AuxType, logic: aux type, carried unchanged.
- NumPipeRegs, 1: number of register stages, 0..4. 0 = combinational passthrough.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- result_i  in  WIDTH  upstream result
- status_i  in  fpnew_pkg::status_t  upstream flags (NV,DZ,OF,UF,NX)
- extension_bit_i  in  1  upstream extension bit
- class_mask_i  in  fpnew_pkg::classmask_e (10)  upstream class mask
- is_class_i  in  1  op was CLASSIFY
- tag_i  in  TagType  tag
- aux_i  in  AuxType  aux
- in_valid_i  in  1  upstream valid
- in_ready_o  out  1  stage can accept
- flush_i  in  1  kill all in-flight ops
- result_o  out  WIDTH  final result
- status_o  out  fpnew_pkg::status_t  flags
- extension_bit_o  out  1  extension bit
- tag_o  out  TagType  tag
- aux_o  out  AuxType  aux
- out_valid_o  out  1  output valid
- out_ready_i  in  1  downstream ready
- busy_o  out  1  any stage valid
- status_sticky_o  out  fpnew_pkg::status_t  accumulated flags (see Optional Feature)
- clear_sticky_i  in  1  clear sticky flags

Behaviour:
- Reset: clock clk_i; rst_i synchronous, active-high.
  - All stage valid bits and all data registers reset to 0.
  - After reset: out_valid_o=0, result_o=0, status_o=0, extension_bit_o=0, tag_o/aux_o='0, busy_o=0, status_sticky_o=0, in_ready_o=1.
- Result merge, applied at the input before stage 0:
  - is_class_i=1: result = class_mask_i zero-extended to WIDTH (truncated to its low WIDTH bits if WIDTH<10); extension_bit = 0.
  - Otherwise: result_i and extension_bit_i are passed through.
- Pipeline for NumPipeRegs=N>0: stages 0..N-1, each with valid_q[k] and a payload register.
  - ready[N] = out_ready_i.
  - ready[k] = ready[k+1] | ~valid_q[k].
  - in_ready_o = ready[0].
  - Stage k loads its payload and sets valid when its upstream valid & ready[k].
  - Stage k clears valid when ready[k] & ~(upstream valid).
  - Payload is held when ready[k]=0.
- Latency and throughput:
  - Exactly N cycles from accept to out_valid_o, with out_ready_i held high.
  - Throughput 1 op/cycle; order preserved; no op duplicated or dropped except by flush.
- N=0: all outputs are a combinational function of the inputs; in_ready_o = out_ready_i; busy_o = 0.
- Flush:
  - flush_i=1 clears every valid_q at the next edge. The payload is don't-care.
  - An input handshaken in the flush cycle is discarded.
  - out_valid_o may be 1 during the flush cycle; a handshake in that cycle counts as delivered.
- Reset vs flush: reset has priority over flush; flush has priority over load.
- busy_o = OR of all valid_q.
- Full pipeline with out_ready_i=0: in_ready_o=0 and all stages hold.
- Simultaneous output pop and input push on a full pipe is allowed: everything shifts.

Optional Feature:
- Macro: FPNEW_NONCOMP_STICKY_STATUS_EN.
- Defined:
  - status_sticky_o is a register.
  - On each output handshake (out_valid_o & out_ready_i) it ORs in status_o.
  - clear_sticky_i=1 clears it at the next edge.
  - If clear and handshake occur in the same cycle, the new value = status_o of that handshake only.
  - Reset value is 0.
- Not defined: status_sticky_o tied to 0, clear_sticky_i ignored, no register is inferred.

Test Plan:
- Classify merge: FP32, N=1, in_valid_i=1, is_class_i=1, class_mask_i=POSNORM (10'h040), result_i=32'hDEADBEEF -> next cycle out_valid_o=1, result_o=32'h00000040, extension_bit_o=0.
- Streaming: N=2, out_ready_i=1, four back-to-back ops with tags 1,2,3,4 -> tags emerge on cycles 2,3,4,5, in_ready_o stays 1.
- Backpressure: N=2, out_ready_i=0, offer tags 5,6,7 -> 5 and 6 accepted, in_ready_o=0 with 7 held upstream; raise out_ready_i -> outputs 5,6,7 in order, no gaps after release.
- Flush: N=3 holding 3 valid ops, flush_i=1 for one cycle while a new op is offered -> next cycle busy_o=0 and out_valid_o=0; the offered op never appears.
- Reset mid-operation: N=2 with 2 valid ops and out_ready_i=0, assert rst_i one cycle -> next cycle out_valid_o=0, result_o=0, busy_o=0, in_ready_o=1.
- Sticky (macro defined): deliver ops with status NV, then OF -> status_sticky_o = NV|OF. Clear together with a handshake of status NX -> status_sticky_o = NX only.
